// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Optional parity support elsewhere is enabled with the UART_RX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;

  // Expected parity bit for up to 32 data bits; zero-extension does not change the XOR.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= UART_IDLE_LVL;
      sync_q <= UART_IDLE_LVL;
      prev_q <= UART_IDLE_LVL;
    end else begin
      meta_q <= i_rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_rx_s    = sync_q;
  assign o_rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: 16x-oversampled deserialiser delivering one byte per good frame.
// Defining UART_RX_PARITY_EN adds a parity bit between data and stop and enables o_parity_err.
module uart_rx_byte #(
  parameter int SIZE_DATA  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_rx,
  output logic                 o_wr_en,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  import uart_pkg::*;

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE_DATA - 1);

  uart_rx_state_e       state_q;
  logic [TICK_W-1:0]    tick_q;
  logic [BIT_W-1:0]     bit_q;
  logic [SIZE_DATA-1:0] shift_q;
  logic [SIZE_DATA-1:0] shift_d;
  logic [SIZE_DATA-1:0] data_q;
  logic                 wr_q;
  logic                 ferr_q;
  logic                 par_bad_s;
  logic                 rx_s;
  logic                 rx_fall;

  uart_rx_sync u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_rx     (i_rx),
    .o_rx_s   (rx_s),
    .o_rx_fall(rx_fall)
  );

  // Shift register with the current line sample inserted at the active bit position.
  always_comb begin
    shift_d        = shift_q;
    shift_d[bit_q] = rx_s;
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic perr_pend_q;

  // Parity verdict is latched mid parity bit and acted on at mid stop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (state_q == PARITY && i_stick && tick_q == TICK_LAST) begin
        perr_pend_q <= (rx_s != calc_parity(32'(shift_q), 1'(PARITY_ODD)));
      end else if (state_q == STOP && i_stick && tick_q == TICK_LAST) begin
        perr_q <= rx_s & perr_pend_q;
      end else begin
        perr_pend_q <= perr_pend_q;
      end
    end
  end

  assign par_bad_s    = perr_pend_q;
  assign o_parity_err = perr_q;
`else
  assign par_bad_s    = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  // Receive FSM with counters and registered output pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Start edge is checked every clock, not just on oversample ticks.
          if (rx_fall) begin
            state_q <= START;
            tick_q  <= '0;
            bit_q   <= '0;
          end
        end
        START: begin
          if (i_stick) begin
            if (tick_q == TICK_MID) begin
              tick_q  <= '0;
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
        DATA: begin
          if (i_stick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              shift_q <= shift_d;
              if (bit_q == BIT_LAST) begin
                bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_stick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
`endif
        STOP: begin
          if (i_stick) begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (!rx_s) begin
                ferr_q  <= 1'b1;
                state_q <= BREAK;
              end else if (par_bad_s) begin
                state_q <= IDLE;
              end else begin
                wr_q    <= 1'b1;
                data_q  <= shift_q;
                state_q <= IDLE;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign o_wr_en     = wr_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule
